// File: rtl/branch_resolve_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_pkg
// Shared types for the fetch-side branch prediction path. The BTB, the fetch
// stage and the resolve queue all exchange predictions using these types.
//   addr_t        : 64-bit instruction address
//   pred_entry_t  : one in-flight prediction (fetch pc, predicted next pc, hit)
//   sat_inc32     : increment that sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package branch_resolve_queue_pkg;

  typedef logic [63:0] addr_t;

  typedef struct packed {
    addr_t pc;
    addr_t next_pc;
    logic  hit;
  } pred_entry_t;

  // Event counters must never wrap back to a small value, so they stop at
  // the maximum representable count.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// -----------------------------------------------------------------------------
// branch_pred_fifo
// Circular buffer holding in-flight predictions in program order.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, entry  : write entry at the tail
//   pop          : drop the head entry
//   clear        : discard every entry (wins over push/pop)
//   head         : oldest entry (meaningful only when not empty)
//   count        : occupancy, 0..DEPTH
//   full, empty  : derived from count
// -----------------------------------------------------------------------------
module branch_pred_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [0:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  entry_t                 entry,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Entry storage needs no reset: validity is tracked purely by the pointers
  // and count, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Reset and clear
  // both return the buffer to empty and take priority over any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
// Buffers every prediction issued at IF and checks them in order against the
// addresses resolved in EXEC. A mismatch flushes all in-flight predictions and
// produces a registered one-cycle redirect to fetch.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   pred_valid_i / pred_ready_o  : prediction handshake from IF
//   pred_pc_i, pred_next_pc_i    : fetch pc and predicted next pc
//   pred_hit_i                   : BTB hit flag (statistics only)
//   res_valid_i / res_ready_o    : resolution handshake from EXEC
//   res_current_addr_i           : address of the resolved instruction
//   res_next_addr_i              : actual next address
//   redirect_o, redirect_pc_o    : restart pulse and address for fetch
//   count_o                      : queue occupancy
//   mispredict_cnt_o             : saturating mispredict count
//   hit_mispredict_cnt_o         : saturating mispredicts on BTB hits
// -----------------------------------------------------------------------------
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pred_valid_i,
  output logic                   pred_ready_o,
  input  addr_t                  pred_pc_i,
  input  addr_t                  pred_next_pc_i,
  input  logic                   pred_hit_i,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  addr_t                  res_current_addr_i,
  input  addr_t                  res_next_addr_i,
  output logic                   redirect_o,
  output addr_t                  redirect_pc_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            mispredict_cnt_o,
  output logic [31:0]            hit_mispredict_cnt_o
);

  pred_entry_t head;
  pred_entry_t new_entry;
  logic        full;
  logic        empty;
  logic        push_fire;
  logic        resolve_fire;
  logic        head_matches;
  logic        mispredict;
  logic        redirect_q;
  addr_t       redirect_pc_q;
  logic [31:0] mispredict_cnt_q;
  logic [31:0] hit_mispredict_cnt_q;

  // Fetch is restarting during the redirect pulse, so nothing it offers in
  // that cycle belongs to the new path.
  assign pred_ready_o = ~full & ~redirect_q;
  assign res_ready_o  = ~empty;

  assign push_fire    = pred_valid_i & pred_ready_o;
  assign resolve_fire = res_valid_i & res_ready_o;
  assign head_matches = (head.pc == res_current_addr_i) &&
                        (head.next_pc == res_next_addr_i);
  assign mispredict   = resolve_fire & ~head_matches;

  assign new_entry.pc      = pred_pc_i;
  assign new_entry.next_pc = pred_next_pc_i;
  assign new_entry.hit     = pred_hit_i;

  // A mispredict clears the whole queue; a prediction pushed in that same
  // cycle is younger than the bad branch and must be dropped too.
  branch_pred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pred_entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_fire & ~mispredict),
    .entry (new_entry),
    .pop   (resolve_fire & head_matches),
    .clear (mispredict),
    .head  (head),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  // Redirect is registered so fetch sees a clean single-cycle pulse one
  // cycle after the failing resolve. The restart pc is only meaningful while
  // the pulse is high, so it simply holds between mispredicts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= res_next_addr_i;
      end
    end
  end

  // Statistics counters; the hit counter separates BTB target errors from
  // fall-through predictions that turned out to be taken branches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_cnt_q     <= '0;
      hit_mispredict_cnt_q <= '0;
    end else if (mispredict) begin
      mispredict_cnt_q <= sat_inc32(mispredict_cnt_q);
      if (head.hit) begin
        hit_mispredict_cnt_q <= sat_inc32(hit_mispredict_cnt_q);
      end
    end
  end

  assign redirect_o           = redirect_q;
  assign redirect_pc_o        = redirect_pc_q;
  assign mispredict_cnt_o     = mispredict_cnt_q;
  assign hit_mispredict_cnt_o = hit_mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
// Directed bench for branch_resolve_queue with DEPTH = 8. Inputs are driven
// 1 ns after each rising edge and outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pred_valid_i;
  logic        pred_ready_o;
  logic [63:0] pred_pc_i;
  logic [63:0] pred_next_pc_i;
  logic        pred_hit_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [63:0] res_current_addr_i;
  logic [63:0] res_next_addr_i;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic [3:0]  count_o;
  logic [31:0] mispredict_cnt_o;
  logic [31:0] hit_mispredict_cnt_o;

  int total = 0;
  int bad   = 0;
  int emptyRun = 0;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .pred_valid_i         (pred_valid_i),
    .pred_ready_o         (pred_ready_o),
    .pred_pc_i            (pred_pc_i),
    .pred_next_pc_i       (pred_next_pc_i),
    .pred_hit_i           (pred_hit_i),
    .res_valid_i          (res_valid_i),
    .res_ready_o          (res_ready_o),
    .res_current_addr_i   (res_current_addr_i),
    .res_next_addr_i      (res_next_addr_i),
    .redirect_o           (redirect_o),
    .redirect_pc_o        (redirect_pc_o),
    .count_o              (count_o),
    .mispredict_cnt_o     (mispredict_cnt_o),
    .hit_mispredict_cnt_o (hit_mispredict_cnt_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Resolutions presented to an empty queue for longer than DEPTH cycles
  // point to a stuck EXEC stage.
  always @(posedge clk_i) begin
    if (!rst_i && res_valid_i && count_o == 4'd0) begin
      emptyRun = emptyRun + 1;
    end else begin
      emptyRun = 0;
    end
    assert (emptyRun <= DEPTH) else begin
      bad = bad + 1;
      $error("[TB] FAIL empty_res_stall observed=%0d cycles required<=%0d", emptyRun, DEPTH);
      emptyRun = 0;
    end
  end

  // Global time limit so a broken DUT cannot hang the run.
  initial begin
    #200000;
    bad = bad + 1;
    $display("[TB] FAIL timeout observed=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [63:0] ppc,
                               input logic [63:0] pnext, input logic phit,
                               input logic rv, input logic [63:0] rcur,
                               input logic [63:0] rnext);
    pred_valid_i       = pv;
    pred_pc_i          = ppc;
    pred_next_pc_i     = pnext;
    pred_hit_i         = phit;
    res_valid_i        = rv;
    res_current_addr_i = rcur;
    res_next_addr_i    = rnext;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Push one prediction with next pc = pc + 4 and advance one cycle.
  task automatic pushSeq(input logic [63:0] pc, input logic hit);
    applyStimulus(1'b1, pc, pc + 64'd4, hit, 1'b0, 64'd0, 64'd0);
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    tick();
    tick();

    // Reset state
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_redirect", 64'(redirect_o), 64'd0);
    checkOutput("rst_redirect_pc", redirect_pc_o, 64'd0);
    checkOutput("rst_mcnt", 64'(mispredict_cnt_o), 64'd0);
    checkOutput("rst_hcnt", 64'(hit_mispredict_cnt_o), 64'd0);
    checkOutput("rst_pred_ready", 64'(pred_ready_o), 64'd1);
    checkOutput("rst_res_ready", 64'(res_ready_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Three correct predictions, resolved in order
    $display("[TB] in-order correct resolves");
    pushSeq(64'h1000, 1'b0);
    pushSeq(64'h1004, 1'b0);
    pushSeq(64'h1008, 1'b0);
    idle();
    checkOutput("t1_count3", 64'(count_o), 64'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h1000 + 64'(4 * i), 64'h1004 + 64'(4 * i));
      tick();
      checkOutput("t1_count", 64'(count_o), 64'(2 - i));
      checkOutput("t1_no_redirect", 64'(redirect_o), 64'd0);
    end
    idle();
    checkOutput("t1_mcnt", 64'(mispredict_cnt_o), 64'd0);

    // Mispredict on the oldest of three entries
    $display("[TB] mispredict flush");
    pushSeq(64'h2000, 1'b0);
    pushSeq(64'h2004, 1'b0);
    pushSeq(64'h2008, 1'b0);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h2000, 64'h3000);
    tick();
    checkOutput("t2_redirect", 64'(redirect_o), 64'd1);
    checkOutput("t2_redirect_pc", redirect_pc_o, 64'h3000);
    checkOutput("t2_count", 64'(count_o), 64'd0);
    checkOutput("t2_mcnt", 64'(mispredict_cnt_o), 64'd1);
    checkOutput("t2_hcnt", 64'(hit_mispredict_cnt_o), 64'd0);
    checkOutput("t2_pred_ready_pulse", 64'(pred_ready_o), 64'd0);
    // A prediction offered during the pulse must not be accepted
    applyStimulus(1'b1, 64'h5000, 64'h5004, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    checkOutput("t2_pulse_end", 64'(redirect_o), 64'd0);
    checkOutput("t2_pulse_nopush", 64'(count_o), 64'd0);
    idle();

    // Fill, then pop/refill so both pointers wrap several times
    $display("[TB] full queue and pointer wrap");
    for (int i = 0; i < DEPTH; i++) begin
      pushSeq(64'h4000 + 64'(4 * i), 1'b0);
    end
    idle();
    checkOutput("t3_full_count", 64'(count_o), 64'd8);
    checkOutput("t3_full_ready", 64'(pred_ready_o), 64'd0);
    // Full: only the pop takes effect
    applyStimulus(1'b1, 64'h4020, 64'h4024, 1'b0, 1'b1, 64'h4000, 64'h4004);
    tick();
    checkOutput("t3_pop_only", 64'(count_o), 64'd7);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 64'h4020 + 64'(4 * k), 64'h4024 + 64'(4 * k), 1'b0,
                    1'b1, 64'h4004 + 64'(4 * k), 64'h4008 + 64'(4 * k));
      tick();
      checkOutput("t3_pair_count", 64'(count_o), 64'd7);
      checkOutput("t3_pair_redirect", 64'(redirect_o), 64'd0);
    end
    // Refill to full: entries 0x4054..0x4070
    pushSeq(64'h4070, 1'b0);
    idle();
    checkOutput("t3_refill_count", 64'(count_o), 64'd8);
    checkOutput("t3_refill_ready", 64'(pred_ready_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h4054 + 64'(4 * i), 64'h4058 + 64'(4 * i));
      tick();
      checkOutput("t3_drain_count", 64'(count_o), 64'(7 - i));
      checkOutput("t3_drain_redirect", 64'(redirect_o), 64'd0);
    end
    idle();
    checkOutput("t3_mcnt", 64'(mispredict_cnt_o), 64'd1);

    // Mispredict on a BTB hit with a simultaneous push
    $display("[TB] hit mispredict with same-cycle push");
    pushSeq(64'h6000, 1'b1);
    pushSeq(64'h6004, 1'b0);
    applyStimulus(1'b1, 64'h6008, 64'h600C, 1'b0, 1'b1, 64'h6000, 64'h7000);
    checkOutput("t4_ready_before", 64'(pred_ready_o), 64'd1);
    tick();
    idle();
    checkOutput("t4_redirect", 64'(redirect_o), 64'd1);
    checkOutput("t4_redirect_pc", redirect_pc_o, 64'h7000);
    checkOutput("t4_count", 64'(count_o), 64'd0);
    checkOutput("t4_mcnt", 64'(mispredict_cnt_o), 64'd2);
    checkOutput("t4_hcnt", 64'(hit_mispredict_cnt_o), 64'd1);
    tick();
    checkOutput("t4_count_after", 64'(count_o), 64'd0);
    checkOutput("t4_pulse_end", 64'(redirect_o), 64'd0);

    // Reset beats a same-cycle mispredict
    $display("[TB] reset during mispredict");
    for (int i = 0; i < 5; i++) begin
      pushSeq(64'h8000 + 64'(4 * i), 1'b1);
    end
    checkOutput("t5_count5", 64'(count_o), 64'd5);
    applyStimulus(1'b1, 64'h8014, 64'h8018, 1'b0, 1'b1, 64'h8000, 64'h9999);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle();
    checkOutput("t5_count", 64'(count_o), 64'd0);
    checkOutput("t5_redirect", 64'(redirect_o), 64'd0);
    checkOutput("t5_redirect_pc", redirect_pc_o, 64'd0);
    checkOutput("t5_mcnt", 64'(mispredict_cnt_o), 64'd0);
    checkOutput("t5_hcnt", 64'(hit_mispredict_cnt_o), 64'd0);

    // Resolution offered to an empty queue is ignored
    $display("[TB] resolve while empty");
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h1234, 64'h5678);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_empty_count", 64'(count_o), 64'd0);
      checkOutput("t6_empty_redirect", 64'(redirect_o), 64'd0);
      checkOutput("t6_empty_ready", 64'(res_ready_o), 64'd0);
    end
    idle();
    checkOutput("t6_empty_mcnt", 64'(mispredict_cnt_o), 64'd0);

    // Counter saturation: preload one below the limit
    $display("[TB] counter saturation");
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt_q;
    pushSeq(64'hA000, 1'b1);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'hA000, 64'hB000);
    tick();
    idle();
    checkOutput("t7_mcnt_max", 64'(mispredict_cnt_o), 64'hFFFF_FFFF);
    checkOutput("t7_redirect1", 64'(redirect_o), 64'd1);
    checkOutput("t7_hcnt1", 64'(hit_mispredict_cnt_o), 64'd1);
    tick();
    pushSeq(64'hA100, 1'b0);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'hA100, 64'hC000);
    tick();
    idle();
    checkOutput("t7_mcnt_stuck", 64'(mispredict_cnt_o), 64'hFFFF_FFFF);
    checkOutput("t7_redirect2", 64'(redirect_o), 64'd1);
    checkOutput("t7_redirect_pc2", redirect_pc_o, 64'hC000);
    checkOutput("t7_hcnt_nohit", 64'(hit_mispredict_cnt_o), 64'd1);
    tick();
    checkOutput("t7_pulse_end", 64'(redirect_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
